ctrl_link_tx: RTL
=================

# ctrl_link_tx

Controller-side serial transmitter for the player-2 remote link. It synchronizes and debounces three active-low buttons (left, right, attack). It then sends their state as a framed, parity-protected UART-style bit stream on a single GPIO wire toward the game board. A frame goes out whenever the debounced state changes and at a periodic refresh interval. The block sits on the controller board in place of the three raw GPIO button wires.

## Interface
- CLKS_PER_BIT, default 434: clk cycles per serial bit (50 MHz / 115200).
- DEBOUNCE_CYCLES, default 65536: consecutive stable synchronized cycles required before a button change is accepted; must be ≥ 1.
- REFRESH_CYCLES, default 833333: maximum spacing between frame starts (60 Hz at 50 MHz); must exceed 7*CLKS_PER_BIT.
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  reset, asynchronous, active-high.
- left_n  in  1  raw left button, active-low, asynchronous.
- right_n  in  1  raw right button, active-low, asynchronous.
- attack_n  in  1  raw attack button, active-low, asynchronous.
- tx  out  1  serial line, idle high.
- busy  out  1  high from the first start-bit cycle through the last stop-bit cycle.
- btn_state  out  3  debounced pressed state {attack, right, left}, active-high.
- frame_count  out  8  frames completed, wraps 255→0.

## Operation
- Input path: 2-flop synchronizer per button, then inversion to active-high, then per-button debounce counter. The counter clears whenever the synchronized value equals the btn_state bit. Otherwise it increments. When it reaches DEBOUNCE_CYCLES, the btn_state bit takes the synchronized value and the counter clears. Glitches shorter than DEBOUNCE_CYCLES never reach btn_state.
- Frame, LSB first: start(0), d0=left, d1=right, d2=attack, d3=seq, parity, stop(1). That is 7 bits, each CLKS_PER_BIT cycles long.
- Parity is even over d0..d3 (parity = XOR of d0..d3).
- seq toggles after every completed frame. Its reset value is 0.
- Trigger fires when either condition holds:
  - btn_state differs from last_sent, or
  - the refresh counter reaches REFRESH_CYCLES-1.
- At frame start, the payload {seq, btn_state} is latched and last_sent is set to btn_state. The refresh counter clears on every frame start.
- FSM states: IDLE → START → DATA (4 bits, index 0..3) → PARITY → STOP → IDLE. A per-bit cycle counter runs 0..CLKS_PER_BIT-1.
- If a trigger is pending in STOP, the next frame's START begins on the cycle after the last stop cycle, with no extra idle cycles.
- Button changes during a frame do not alter the latched payload. The change is detected against last_sent and sent in the next frame.
- A pending flag resets to 1, so one frame is sent right after reset release.

## Timing
- Reset values: tx=1, busy=0, btn_state=000, frame_count=0, seq=0, FSM=IDLE, all counters 0, last_sent=000, pending=1.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously). The partial frame is abandoned and no frame_count increment occurs.
- After rst deasserts, tx falls (START) on the first clk edge.
- Raw button change held stable:
  - btn_state updates 2+DEBOUNCE_CYCLES edges after the raw change is sampled.
  - tx falls 1 edge later if IDLE.
- tx and busy are registered. Each bit lasts exactly CLKS_PER_BIT cycles. A frame lasts 7*CLKS_PER_BIT cycles.
- frame_count and seq update on the final cycle of STOP.
- Simultaneous change and refresh trigger produce one frame, not two.

## Test plan
Parameters for all scenarios: CLKS_PER_BIT=4, DEBOUNCE_CYCLES=8, REFRESH_CYCLES=200.
- Reset then release, buttons idle:
  - tx=0 for cycles 1-4, then 0,0,0,0 (data), 0 (parity), 1 (stop), each 4 cycles.
  - busy high for 28 cycles, then frame_count=1.
- Hold left_n=0 stable from idle:
  - btn_state=001 after 10 cycles.
  - Next frame data = 1,0,0,seq=1, parity=0.
- Pulse attack_n low for 5 cycles: btn_state stays 000 and no change-triggered frame is sent.
- No input activity: frame starts are 200 cycles apart, seq alternates, and frame_count increments per frame.
- Change right during a frame: the current frame keeps its old payload, and a second frame carrying right=1 starts the cycle after stop, with busy held continuously high.
- Assert rst at frame bit 3: tx=1 and busy=0 immediately, frame_count=0. After release, a fresh frame starts with seq=0.

Source files
------------

// File: rtl/ctrl_link_tx.sv
// Player-2 controller link transmitter: synchronizes and debounces three active-low buttons
// and sends their state as 7-bit UART-style frames on change and at a periodic refresh.
module ctrl_link_tx #(
  parameter int unsigned CLKS_PER_BIT    = 434,
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned REFRESH_CYCLES  = 833333
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left_n,
  input  logic       right_n,
  input  logic       attack_n,
  output logic       tx,
  output logic       busy,
  output logic [2:0] btn_state,
  output logic [7:0] frame_count
);

  localparam int unsigned BitW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RefW = $clog2(REFRESH_CYCLES);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // Input path
  logic [2:0]     sync1_q, sync2_q, sync_act;
  logic [2:0]     btn_d, btn_q;
  logic [DbW-1:0] db_cnt_d [3];
  logic [DbW-1:0] db_cnt_q [3];

  assign sync_act = ~sync2_q;

  always_comb begin
    btn_d = btn_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync_act[i] == btn_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES)) begin
        btn_d[i]    = sync_act[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
      end
    end
  end

  // Synchronizers reset to the released level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      btn_q   <= 3'b000;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= {attack_n, right_n, left_n};
      sync2_q <= sync1_q;
      btn_q   <= btn_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Frame FSM
  state_e          state_q;
  logic [BitW-1:0] bit_cnt_q;
  logic [1:0]      idx_q;
  logic [3:0]      payload_q;
  logic [2:0]      last_sent_q;
  logic [RefW-1:0] refresh_q;
  logic            pending_q, seq_q, tx_q, busy_q;
  logic [7:0]      frame_count_q;

  logic bit_last, frame_end, refresh_hit, trig, start, seq_next;

  assign bit_last    = bit_cnt_q == BitW'(CLKS_PER_BIT - 1);
  assign frame_end   = (state_q == StStop) && bit_last;
  assign refresh_hit = refresh_q == RefW'(REFRESH_CYCLES - 1);
  assign trig        = pending_q || (btn_q != last_sent_q) || refresh_hit;
  assign start       = trig && ((state_q == StIdle) || frame_end);
  assign seq_next    = frame_end ? ~seq_q : seq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      idx_q         <= 2'd0;
      payload_q     <= 4'd0;
      last_sent_q   <= 3'b000;
      refresh_q     <= '0;
      pending_q     <= 1'b1;
      seq_q         <= 1'b0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      if (start) begin
        refresh_q <= '0;
        pending_q <= 1'b0;
      end else begin
        if (!refresh_hit) refresh_q <= refresh_q + RefW'(1);
        else              pending_q <= 1'b1;
      end

      if (frame_end) begin
        frame_count_q <= frame_count_q + 8'd1;
        seq_q         <= ~seq_q;
      end

      if (state_q != StIdle) begin
        bit_cnt_q <= bit_last ? '0 : bit_cnt_q + BitW'(1);
      end

      if (start) begin
        // Seq already reflects a frame finishing on this same edge.
        state_q     <= StStart;
        bit_cnt_q   <= '0;
        tx_q        <= 1'b0;
        busy_q      <= 1'b1;
        payload_q   <= {seq_next, btn_q};
        last_sent_q <= btn_q;
      end else begin
        unique case (state_q)
          StIdle: ;
          StStart: begin
            if (bit_last) begin
              state_q <= StData;
              idx_q   <= 2'd0;
              tx_q    <= payload_q[0];
            end
          end
          StData: begin
            if (bit_last) begin
              if (idx_q == 2'd3) begin
                state_q <= StParity;
                tx_q    <= ^payload_q;
              end else begin
                idx_q <= idx_q + 2'd1;
                tx_q  <= payload_q[idx_q + 2'd1];
              end
            end
          end
          StParity: begin
            if (bit_last) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end
          end
          StStop: begin
            if (bit_last) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign btn_state   = btn_q;
  assign frame_count = frame_count_q;

endmodule
